// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: sync pulses, active flag, pixel coordinates.
// Optional frame counter is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int   HORI_ACTIVE = 1024,
  parameter int   HORI_FP     = 24,
  parameter int   HORI_SYNCP  = 136,
  parameter int   HORI_BP     = 160,
  parameter int   VERT_ACTIVE = 768,
  parameter int   VERT_FP     = 3,
  parameter int   VERT_SYNCP  = 6,
  parameter int   VERT_BP     = 29,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hs,
  output logic        vs,
  output logic        video_active,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        frame_start,
  output logic        line_end,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = HORI_ACTIVE + HORI_FP + HORI_SYNCP + HORI_BP;
  localparam int V_TOTAL = VERT_ACTIVE + VERT_FP + VERT_SYNCP + VERT_BP;

  localparam logic [11:0] H_ACT      = 12'(HORI_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(HORI_ACTIVE + HORI_FP);
  localparam logic [11:0] H_SYNC_END = 12'(HORI_ACTIVE + HORI_FP + HORI_SYNCP);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT      = 12'(VERT_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(VERT_ACTIVE + VERT_FP);
  localparam logic [11:0] V_SYNC_END = 12'(VERT_ACTIVE + VERT_FP + VERT_SYNCP);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        active_q, active_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        fs_q, fs_d;
  logic        le_q, le_d;

  // Outputs are decoded from the counter state present at the edge, so they
  // trail the counters by exactly one cycle and stay mutually aligned.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
    active_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d     = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_d     = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
    x_d      = active_d ? h_cnt_q : 12'd0;
    y_d      = active_d ? v_cnt_q : 12'd0;
    fs_d     = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    le_d     = (h_cnt_q == H_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q  <= 12'd0;
      v_cnt_q  <= 12'd0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      active_q <= 1'b0;
      x_q      <= 12'd0;
      y_q      <= 12'd0;
      fs_q     <= 1'b0;
      le_q     <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= fs_d;
      le_q     <= le_d;
    end
  end

  assign hs           = hs_q;
  assign vs           = vs_q;
  assign video_active = active_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign frame_start  = fs_q;
  assign line_end     = le_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_wrap_q;
  logic [15:0] frame_cnt_q;

  // The wrap is remembered for one cycle so the count changes together with
  // the frame_start output rather than with line_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_wrap_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      frame_wrap_q <= (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
      if (frame_wrap_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 1024x768 instance for line timing, 14x7 instance for
// frame-level behaviour (vertical sync, frame period, frame counter).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;

  logic        b_hs, b_vs, b_va, b_fs, b_le;
  logic [11:0] b_x, b_y;
  logic [15:0] b_fc;
  logic        s_hs, s_vs, s_va, s_fs, s_le;
  logic [11:0] s_x, s_y;
  logic [15:0] s_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_b (
    .clk(clk), .rst(rst_b), .hs(b_hs), .vs(b_vs), .video_active(b_va),
    .x_pos(b_x), .y_pos(b_y), .frame_start(b_fs), .line_end(b_le), .frame_cnt(b_fc)
  );

  vga_timing_gen #(
    .HORI_ACTIVE(8), .HORI_FP(2), .HORI_SYNCP(3), .HORI_BP(1),
    .VERT_ACTIVE(4), .VERT_FP(1), .VERT_SYNCP(1), .VERT_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst_s), .hs(s_hs), .vs(s_vs), .video_active(s_va),
    .x_pos(s_x), .y_pos(s_y), .frame_start(s_fs), .line_end(s_le), .frame_cnt(s_fc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_b = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (b_fs !== 1'b0 || b_le !== 1'b0 || s_fs !== 1'b0 || s_le !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL rst_pulses: %0d cycles with a pulse, required 0", pulses);
    end
    total++;
    if ({b_hs, b_vs, b_va, b_fs, b_le} !== 5'b11000) begin
      bad++;
      $display("FAIL rst_big_flags: hs,vs,va,fs,le=%b required 11000", {b_hs, b_vs, b_va, b_fs, b_le});
    end
    total++;
    if (b_x !== 12'd0 || b_y !== 12'd0 || b_fc !== 16'd0) begin
      bad++;
      $display("FAIL rst_big_values: x=%0d y=%0d fc=%0d required 0 0 0", b_x, b_y, b_fc);
    end
    total++;
    if (s_hs !== 1'b0 || s_vs !== 1'b1) begin
      bad++;
      $display("FAIL rst_small_sync: hs=%b vs=%b required 0 1", s_hs, s_vs);
    end
    rst_b = 1'b0;
  endtask

  task automatic test_big_lines();
    int mm[8] = '{default: 0};
    string nm[8] = '{"hs", "vs", "active", "x", "y", "fstart", "lend", "fcnt"};
    int hs_low = 0;
    int le_cnt = 0;
    int h, v;
    logic e_hs, e_va, e_fs, e_le;
    logic [11:0] e_x, e_y;
    for (int k = 0; k < 2 * 1344 + 100; k++) begin
      step();
      h = k % 1344;
      v = k / 1344;
      e_hs = !(h >= 1048 && h < 1184);
      e_va = (h < 1024) && (v < 768);
      e_x  = e_va ? 12'(h) : 12'd0;
      e_y  = e_va ? 12'(v) : 12'd0;
      e_fs = (h == 0) && (v == 0);
      e_le = (h == 1343);
      if (b_hs !== e_hs) mm[0]++;
      if (b_vs !== 1'b1) mm[1]++;
      if (b_va !== e_va) mm[2]++;
      if (b_x !== e_x) mm[3]++;
      if (b_y !== e_y) mm[4]++;
      if (b_fs !== e_fs) mm[5]++;
      if (b_le !== e_le) mm[6]++;
      if (b_fc !== 16'd0) mm[7]++;
      if (k < 1344 && b_hs === 1'b0) hs_low++;
      if (b_le === 1'b1) le_cnt++;
      if (k == 0) begin
        total++;
        if (b_fs !== 1'b1 || b_va !== 1'b1 || b_x !== 12'd0 || b_y !== 12'd0) begin
          bad++;
          $display("FAIL edge_r: fs=%b va=%b x=%0d y=%0d required 1 1 0 0", b_fs, b_va, b_x, b_y);
        end
      end
      if (k == 1023) begin
        total++;
        if (b_x !== 12'd1023) begin
          bad++;
          $display("FAIL last_active_x: x=%0d required 1023", b_x);
        end
      end
      if (k == 1024) begin
        total++;
        if (b_va !== 1'b0 || b_x !== 12'd0) begin
          bad++;
          $display("FAIL first_blank: va=%b x=%0d required 0 0", b_va, b_x);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mm[i] != 0) begin
        bad++;
        $display("FAIL big_%s: %0d mismatching cycles, required 0", nm[i], mm[i]);
      end
    end
    total++;
    if (hs_low != 136) begin
      bad++;
      $display("FAIL hsync_width: %0d low cycles, required 136", hs_low);
    end
    total++;
    if (le_cnt != 2) begin
      bad++;
      $display("FAIL line_end_count: %0d pulses, required 2", le_cnt);
    end
  endtask

  task automatic test_big_mid_reset();
    rst_b = 1'b1;
    step();
    total++;
    if ({b_hs, b_vs, b_va, b_fs, b_le} !== 5'b11000 || b_x !== 12'd0 || b_y !== 12'd0) begin
      bad++;
      $display("FAIL big_mid_rst: flags=%b x=%0d y=%0d required 11000 0 0",
               {b_hs, b_vs, b_va, b_fs, b_le}, b_x, b_y);
    end
    rst_b = 1'b0;
    step();
    total++;
    if (b_fs !== 1'b1 || b_va !== 1'b1 || b_x !== 12'd0 || b_y !== 12'd0) begin
      bad++;
      $display("FAIL big_restart: fs=%b va=%b x=%0d y=%0d required 1 1 0 0", b_fs, b_va, b_x, b_y);
    end
    step();
    total++;
    if (b_x !== 12'd1 || b_fs !== 1'b0) begin
      bad++;
      $display("FAIL big_restart_next: x=%0d fs=%b required 1 0", b_x, b_fs);
    end
  endtask

  task automatic test_small_frames();
    int mm[8] = '{default: 0};
    string nm[8] = '{"hs", "vs", "active", "x", "y", "fstart", "lend", "fcnt"};
    int vs_low = 0;
    int hs_high = 0;
    int last_fs = -1;
    int bad_gap = 0;
    int h, v;
    logic e_hs, e_vs, e_va, e_fs, e_le;
    logic [11:0] e_x, e_y;
    logic [15:0] e_fc;
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    for (int k = 0; k < 3 * 98 + 42; k++) begin
      step();
      h = k % 14;
      v = (k / 14) % 7;
      e_hs = (h >= 10) && (h <= 12);
      e_vs = (v != 5);
      e_va = (h < 8) && (v < 4);
      e_x  = e_va ? 12'(h) : 12'd0;
      e_y  = e_va ? 12'(v) : 12'd0;
      e_fs = (h == 0) && (v == 0);
      e_le = (h == 13);
`ifdef VGA_TIMING_FRAME_CNT_EN
      e_fc = 16'(k / 98);
`else
      e_fc = 16'd0;
`endif
      if (s_hs !== e_hs) mm[0]++;
      if (s_vs !== e_vs) mm[1]++;
      if (s_va !== e_va) mm[2]++;
      if (s_x !== e_x) mm[3]++;
      if (s_y !== e_y) mm[4]++;
      if (s_fs !== e_fs) mm[5]++;
      if (s_le !== e_le) mm[6]++;
      if (s_fc !== e_fc) mm[7]++;
      if (k < 98 && s_vs === 1'b0) vs_low++;
      if (k < 14 && s_hs === 1'b1) hs_high++;
      if (s_fs === 1'b1) begin
        if (last_fs >= 0 && k - last_fs != 98) bad_gap++;
        last_fs = k;
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mm[i] != 0) begin
        bad++;
        $display("FAIL small_%s: %0d mismatching cycles, required 0", nm[i], mm[i]);
      end
    end
    total++;
    if (vs_low != 14) begin
      bad++;
      $display("FAIL small_vsync_width: %0d low cycles, required 14", vs_low);
    end
    total++;
    if (hs_high != 3) begin
      bad++;
      $display("FAIL small_hsync_width: %0d high cycles, required 3", hs_high);
    end
    total++;
    if (bad_gap != 0 || last_fs != 294) begin
      bad++;
      $display("FAIL frame_period: bad gaps=%0d last start=%0d required 0 294", bad_gap, last_fs);
    end
    // Counters now sit at the start of line 3 of the fourth frame.
    rst_s = 1'b1;
    step();
    total++;
    if ({s_hs, s_vs, s_va, s_fs, s_le} !== 5'b01000 || s_fc !== 16'd0) begin
      bad++;
      $display("FAIL small_mid_rst: flags=%b fc=%0d required 01000 0", {s_hs, s_vs, s_va, s_fs, s_le}, s_fc);
    end
    rst_s = 1'b0;
    step();
    total++;
    if (s_fs !== 1'b1 || s_va !== 1'b1 || s_x !== 12'd0 || s_y !== 12'd0 || s_fc !== 16'd0) begin
      bad++;
      $display("FAIL small_restart: fs=%b va=%b x=%0d y=%0d fc=%0d required 1 1 0 0 0",
               s_fs, s_va, s_x, s_y, s_fc);
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt_wrap();
    int n = 0;
    force dut_s.frame_cnt_q = 16'hFFFF;
    step();
    release dut_s.frame_cnt_q;
    step();
    while (s_fs !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n >= 200 || s_fc !== 16'h0000) begin
      bad++;
      $display("FAIL fcnt_wrap: fc=%h after %0d cycles, required 0000", s_fc, n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_big_lines();
    test_big_mid_reset();
    test_small_frames();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
